mc_ctrl_fsm: RTL and testbench

//  Multi-cycle control sequencer for the shared-ALU/shared-memory datapath.

---
 rtl/mc_ctrl_pkg.sv | 61 ++++++
 rtl/mc_ctrl_decode.sv | 33 +++
 rtl/mc_ctrl_fsm.sv | 237 +++++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control sequencer: opcodes, functs,
// FSM states, datapath mux selects and the instruction class flags.
package mc_ctrl_pkg;

   localparam logic [5:0] OP_R      = 6'b000000;
   localparam logic [5:0] OP_LW     = 6'b100011;
   localparam logic [5:0] OP_SW     = 6'b101011;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_NANDI  = 6'b010000;
   localparam logic [5:0] OP_BLEZAL = 6'b100100;
   localparam logic [5:0] OP_BALV   = 6'b100000;
   localparam logic [5:0] OP_JALPC  = 6'b011111;

   localparam logic [5:0] FN_BRV    = 6'b010100;
   localparam logic [5:0] FN_JMXOR  = 6'b100010;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_FETCH  = 4'd1,
      ST_DECODE = 4'd2,
      ST_MEMADR = 4'd3,
      ST_MEMRD  = 4'd4,
      ST_MEMWB  = 4'd5,
      ST_MEMWR  = 4'd6,
      ST_REXEC  = 4'd7,
      ST_RWB    = 4'd8,
      ST_IEXEC  = 4'd9,
      ST_IWB    = 4'd10,
      ST_BEQ    = 4'd11,
      ST_BRV    = 4'd12,
      ST_JMXA   = 4'd13,
      ST_JMXRD  = 4'd14,
      ST_LINK   = 4'd15
   } state_e;

   typedef enum logic [1:0] {RD_RT = 2'b00, RD_RD = 2'b01, RD_RA = 2'b10} regdest_e;
   typedef enum logic [1:0] {MR_ALU = 2'b00, MR_MDR = 2'b01, MR_PC = 2'b10} memtoreg_e;
   typedef enum logic [1:0] {SB_RT = 2'b00, SB_FOUR = 2'b01, SB_IMM = 2'b10, SB_IMM_SH = 2'b11} alusrcb_e;
   typedef enum logic [1:0] {AO_ADD = 2'b00, AO_SUB = 2'b01, AO_FUNCT = 2'b10, AO_NAND = 2'b11} aluop_e;
   typedef enum logic [1:0] {PS_ALU = 2'b00, PS_ALUOUT = 2'b01, PS_MDR = 2'b10, PS_RS = 2'b11} pcsrc_e;

   typedef struct packed {
      logic lw;
      logic sw;
      logic rtype;
      logic brv;
      logic jmxor;
      logic beq;
      logic nandi;
      logic blezal;
      logic balv;
      logic jalpc;
      logic illegal;
   } instr_class_t;

   // States that own the shared memory port and therefore wait on mem_ready.
   function automatic logic is_mem_state(input state_e s);
      return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR) || (s == ST_JMXRD);
   endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode/funct classifier: exactly one class flag is high,
// with illegal covering every unsupported opcode.
module mc_ctrl_decode
   import mc_ctrl_pkg::*;
(
   input  logic [5:0]   opcode,
   input  logic [5:0]   functcode,
   output instr_class_t cls
);

   always_comb begin
      // NOTE: every bit gets a default before the case, so no path can infer a latch.
      cls = '0;
      unique case (opcode)
         OP_R: begin
            unique case (functcode)
               FN_BRV:   cls.brv   = 1'b1;
               FN_JMXOR: cls.jmxor = 1'b1;
               default:  cls.rtype = 1'b1;
            endcase
         end
         OP_LW:     cls.lw     = 1'b1;
         OP_SW:     cls.sw     = 1'b1;
         OP_BEQ:    cls.beq    = 1'b1;
         OP_NANDI:  cls.nandi  = 1'b1;
         OP_BLEZAL: cls.blezal = 1'b1;
         OP_BALV:   cls.balv   = 1'b1;
         OP_JALPC:  cls.jalpc  = 1'b1;
         default:   cls.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control sequencer for the shared-ALU/shared-memory datapath.
// Optional performance counters are built when MC_CTRL_PERF_EN is defined.
module mc_ctrl_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int WAIT_TIMEOUT = 15,
   parameter int CW           = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  opcode,
   input  logic [5:0]  functcode,
   input  logic        status_z,
   input  logic        status_n,
   input  logic        status_v,
   input  logic        mem_ready,
   output logic        pcwrite,
   output logic        pcwritecond,
   output logic        iord,
   output logic        memread,
   output logic        memwrite,
   output logic        irwrite,
   output logic [1:0]  regdest,
   output logic [1:0]  memtoreg,
   output logic        alusrca,
   output logic [1:0]  alusrcb,
   output logic [1:0]  aluop,
   output logic [1:0]  pcsrc,
   output logic        regwrite,
   output logic        status_write,
   output logic        illegal_op,
   output logic        mem_err
`ifdef MC_CTRL_PERF_EN
   ,
   output logic [31:0] instr_cnt,
   output logic [31:0] stall_cnt
`endif
);

   state_e       state_q, state_d;
   logic [CW-1:0] wait_q, wait_d;
   instr_class_t cls;
   logic         mem_st;
   logic         abort;

   mc_ctrl_decode u_decode (
      .opcode    (opcode),
      .functcode (functcode),
      .cls       (cls)
   );

   assign mem_st = is_mem_state(state_q);
   assign abort  = mem_st && (wait_q == CW'(WAIT_TIMEOUT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         wait_q  <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge values.
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pcwrite      = 1'b0;
      pcwritecond  = 1'b0;
      iord         = 1'b0;
      memread      = 1'b0;
      memwrite     = 1'b0;
      irwrite      = 1'b0;
      regdest      = RD_RT;
      memtoreg     = MR_ALU;
      alusrca      = 1'b0;
      alusrcb      = SB_RT;
      aluop        = AO_ADD;
      pcsrc        = PS_ALU;
      regwrite     = 1'b0;
      status_write = 1'b0;
      illegal_op   = 1'b0;
      mem_err      = abort;

      unique case (state_q)
         ST_IDLE: state_d = ST_FETCH;
         ST_FETCH: begin
            memread = 1'b1;
            alusrcb = SB_FOUR;
            // A timed-out fetch leaves the PC alone and simply retries.
            if (abort) begin
               state_d = ST_FETCH;
            end else if (mem_ready) begin
               irwrite = 1'b1;
               pcwrite = 1'b1;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            alusrcb = SB_IMM_SH;
            if (cls.lw || cls.sw)                        state_d = ST_MEMADR;
            else if (cls.rtype)                          state_d = ST_REXEC;
            else if (cls.brv)                            state_d = ST_BRV;
            else if (cls.jmxor)                          state_d = ST_JMXA;
            else if (cls.beq)                            state_d = ST_BEQ;
            else if (cls.nandi)                          state_d = ST_IEXEC;
            else if (cls.blezal || cls.balv || cls.jalpc) state_d = ST_LINK;
            else begin
               illegal_op = cls.illegal;
               state_d    = ST_FETCH;
            end
         end
         ST_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = SB_IMM;
            state_d = cls.sw ? ST_MEMWR : ST_MEMRD;
         end
         ST_MEMRD: begin
            memread = 1'b1;
            iord    = 1'b1;
            if (abort)          state_d = ST_FETCH;
            else if (mem_ready) state_d = ST_MEMWB;
         end
         ST_MEMWB: begin
            regwrite     = 1'b1;
            memtoreg     = MR_MDR;
            status_write = 1'b1;
            state_d      = ST_FETCH;
         end
         ST_MEMWR: begin
            iord = 1'b1;
            if (abort) begin
               state_d = ST_FETCH;
            end else if (mem_ready) begin
               memwrite     = 1'b1;
               status_write = 1'b1;
               state_d      = ST_FETCH;
            end
         end
         ST_REXEC: begin
            alusrca = 1'b1;
            aluop   = AO_FUNCT;
            state_d = ST_RWB;
         end
         ST_RWB: begin
            regwrite     = 1'b1;
            regdest      = RD_RD;
            status_write = 1'b1;
            state_d      = ST_FETCH;
         end
         ST_IEXEC: begin
            alusrca = 1'b1;
            alusrcb = SB_IMM;
            aluop   = AO_NAND;
            state_d = ST_IWB;
         end
         ST_IWB: begin
            regwrite = 1'b1;
            state_d  = ST_FETCH;
         end
         ST_BEQ: begin
            alusrca      = 1'b1;
            aluop        = AO_SUB;
            pcwritecond  = 1'b1;
            pcsrc        = PS_ALUOUT;
            status_write = 1'b1;
            state_d      = ST_FETCH;
         end
         ST_BRV: begin
            pcsrc   = PS_RS;
            pcwrite = status_v;
            state_d = ST_FETCH;
         end
         ST_JMXA: begin
            alusrca = 1'b1;
            aluop   = AO_FUNCT;
            state_d = ST_JMXRD;
         end
         ST_JMXRD: begin
            memread = 1'b1;
            iord    = 1'b1;
            pcsrc   = PS_MDR;
            if (abort) begin
               state_d = ST_FETCH;
            end else if (mem_ready) begin
               pcwrite = 1'b1;
               state_d = ST_FETCH;
            end
         end
         ST_LINK: begin
            // Link is written unconditionally; only the PC update depends on the condition.
            regwrite = 1'b1;
            regdest  = RD_RA;
            memtoreg = MR_PC;
            pcsrc    = PS_ALUOUT;
            pcwrite  = (cls.blezal && (status_z || status_n)) ||
                       (cls.balv && status_v) || cls.jalpc;
            state_d  = ST_FETCH;
         end
         default: state_d = ST_IDLE;
      endcase

      if ((state_d != state_q) || abort) wait_d = '0;
      else if (mem_st && !mem_ready)     wait_d = wait_q + 1'b1;
      else                               wait_d = wait_q;
   end

`ifdef MC_CTRL_PERF_EN
   logic [31:0] instr_cnt_q, instr_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic        completing;

   // Aborts, illegal opcodes and the IDLE exit do not count as retired instructions.
   assign completing = (state_d == ST_FETCH) && !abort &&
                       (state_q inside {ST_MEMWB, ST_MEMWR, ST_RWB, ST_IWB,
                                        ST_BEQ, ST_BRV, ST_JMXRD, ST_LINK});

   always_comb begin
      instr_cnt_d = completing ? instr_cnt_q + 32'd1 : instr_cnt_q;
      stall_cnt_d = (mem_st && !mem_ready) ? stall_cnt_q + 32'd1 : stall_cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         instr_cnt_q <= instr_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign instr_cnt = instr_cnt_q;
   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: per-cycle expected control words are
// queued by the driver and compared at the falling edge by a monitor.
module tb_mc_ctrl_fsm;

   typedef struct packed {
      logic       pcwrite;
      logic       pcwritecond;
      logic       iord;
      logic       memread;
      logic       memwrite;
      logic       irwrite;
      logic [1:0] regdest;
      logic [1:0] memtoreg;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic [1:0] pcsrc;
      logic       regwrite;
      logic       status_write;
      logic       illegal_op;
      logic       mem_err;
   } outs_t;

   typedef enum {
      K_FETCH, K_DECODE, K_ILLEGAL, K_MEMADR, K_MEMRD, K_MEMWB, K_MEMWR,
      K_REXEC, K_RWB, K_IEXEC, K_IWB, K_BEQ, K_BRV, K_JMXA, K_JMXRD, K_LINK
   } kind_e;

   typedef struct {
      string tag;
      outs_t exp;
   } sb_item_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode, functcode;
   logic       status_z, status_n, status_v, mem_ready;
   logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
   logic [1:0] regdest, memtoreg, alusrcb, aluop, pcsrc;
   logic       alusrca, regwrite, status_write, illegal_op, mem_err;
`ifdef MC_CTRL_PERF_EN
   logic [31:0] instr_cnt, stall_cnt;
`endif

   outs_t      outs;
   sb_item_t   sb_q[$];
   int         n_cmp = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   mc_ctrl_fsm dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .opcode       (opcode),
      .functcode    (functcode),
      .status_z     (status_z),
      .status_n     (status_n),
      .status_v     (status_v),
      .mem_ready    (mem_ready),
      .pcwrite      (pcwrite),
      .pcwritecond  (pcwritecond),
      .iord         (iord),
      .memread      (memread),
      .memwrite     (memwrite),
      .irwrite      (irwrite),
      .regdest      (regdest),
      .memtoreg     (memtoreg),
      .alusrca      (alusrca),
      .alusrcb      (alusrcb),
      .aluop        (aluop),
      .pcsrc        (pcsrc),
      .regwrite     (regwrite),
      .status_write (status_write),
      .illegal_op   (illegal_op),
      .mem_err      (mem_err)
`ifdef MC_CTRL_PERF_EN
      ,
      .instr_cnt    (instr_cnt),
      .stall_cnt    (stall_cnt)
`endif
   );

   assign outs = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, regdest, memtoreg,
                  alusrca, alusrcb, aluop, pcsrc, regwrite, status_write, illegal_op, mem_err};

   task automatic check(input string tag, input logic [20:0] got, input logic [20:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %06h expected %06h", tag, got, exp);
      end
   endtask

   // Expected control word for one cycle of a given state, straight from the state table.
   function automatic outs_t exp_of(input kind_e k, input bit rdy, input bit cond, input bit abrt);
      outs_t e = '0;
      bit    go = rdy && !abrt;
      e.mem_err = abrt;
      case (k)
         K_FETCH:   begin e.memread = 1; e.alusrcb = 2'b01; e.irwrite = go; e.pcwrite = go; end
         K_DECODE:  e.alusrcb = 2'b11;
         K_ILLEGAL: begin e.alusrcb = 2'b11; e.illegal_op = 1; end
         K_MEMADR:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
         K_MEMRD:   begin e.memread = 1; e.iord = 1; end
         K_MEMWB:   begin e.regwrite = 1; e.memtoreg = 2'b01; e.status_write = 1; end
         K_MEMWR:   begin e.iord = 1; e.memwrite = go; e.status_write = go; end
         K_REXEC:   begin e.alusrca = 1; e.aluop = 2'b10; end
         K_RWB:     begin e.regwrite = 1; e.regdest = 2'b01; e.status_write = 1; end
         K_IEXEC:   begin e.alusrca = 1; e.alusrcb = 2'b10; e.aluop = 2'b11; end
         K_IWB:     e.regwrite = 1;
         K_BEQ:     begin e.alusrca = 1; e.aluop = 2'b01; e.pcwritecond = 1; e.pcsrc = 2'b01;
                          e.status_write = 1; end
         K_BRV:     begin e.pcsrc = 2'b11; e.pcwrite = cond; end
         K_JMXA:    begin e.alusrca = 1; e.aluop = 2'b10; end
         K_JMXRD:   begin e.memread = 1; e.iord = 1; e.pcsrc = 2'b10; e.pcwrite = go; end
         K_LINK:    begin e.regwrite = 1; e.regdest = 2'b10; e.memtoreg = 2'b10; e.pcsrc = 2'b01;
                          e.pcwrite = cond; end
         default:   e = '0;
      endcase
      return e;
   endfunction

   // One clock of stimulus; mem_ready is randomised where the state must ignore it.
   task automatic step(input string tag, input kind_e k, input bit rdy = 1'b1,
                       input bit cond = 1'b0, input bit abrt = 1'b0);
      sb_item_t it;
      if (k inside {K_FETCH, K_MEMRD, K_MEMWR, K_JMXRD}) mem_ready = rdy;
      else                                               mem_ready = 1'($urandom_range(0, 1));
      it.tag = tag;
      it.exp = exp_of(k, rdy, cond, abrt);
      sb_q.push_back(it);
      @(posedge clk);
      #1;
   endtask

   task automatic set_ir(input logic [5:0] op, input logic [5:0] fn);
      opcode    = op;
      functcode = fn;
   endtask

   task automatic set_flags(input logic z, input logic n, input logic v);
      status_z = z;
      status_n = n;
      status_v = v;
   endtask

   always @(negedge clk) begin
      if (sb_q.size() != 0) begin
         sb_item_t it;
         it = sb_q.pop_front();
         check(it.tag, outs, it.exp);
      end
   end

   initial begin
      rst_n = 1'b0;
      mem_ready = 1'b1;
      set_ir(6'b000000, 6'b100000);
      set_flags(0, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_outs", outs, '0);
      rst_n = 1'b1;
      #1;
      check("idle_outs", outs, '0);
      @(posedge clk);
      #1;

      // R-type add
      step("radd:fetch", K_FETCH);
      step("radd:decode", K_DECODE);
      step("radd:rexec", K_REXEC);
      step("radd:rwb", K_RWB);

      // lw with three stall cycles
      set_ir(6'b100011, 6'b000000);
      step("lw:fetch", K_FETCH);
      step("lw:decode", K_DECODE);
      step("lw:memadr", K_MEMADR);
      for (int i = 0; i < 3; i++) step("lw:memrd_wait", K_MEMRD, 1'b0);
      step("lw:memrd", K_MEMRD);
      step("lw:memwb", K_MEMWB);

      // link family
      set_ir(6'b100000, 6'b000000);
      set_flags(0, 0, 0);
      step("balv0:fetch", K_FETCH);
      step("balv0:decode", K_DECODE);
      step("balv0:link", K_LINK, 1'b1, 1'b0);
      set_flags(0, 0, 1);
      step("balv1:fetch", K_FETCH);
      step("balv1:decode", K_DECODE);
      step("balv1:link", K_LINK, 1'b1, 1'b1);
      set_ir(6'b100100, 6'b000000);
      set_flags(0, 1, 1);
      step("blezal_n:fetch", K_FETCH);
      step("blezal_n:decode", K_DECODE);
      step("blezal_n:link", K_LINK, 1'b1, 1'b1);
      set_flags(0, 0, 1);
      step("blezal_nt:fetch", K_FETCH);
      step("blezal_nt:decode", K_DECODE);
      step("blezal_nt:link", K_LINK, 1'b1, 1'b0);
      set_ir(6'b011111, 6'b000000);
      set_flags(0, 0, 0);
      step("jalpc:fetch", K_FETCH);
      step("jalpc:decode", K_DECODE);
      step("jalpc:link", K_LINK, 1'b1, 1'b1);

      // jmxor with one stall in the read, then brv taken and not taken
      set_ir(6'b000000, 6'd34);
      step("jmxor:fetch", K_FETCH);
      step("jmxor:decode", K_DECODE);
      step("jmxor:jmxa", K_JMXA);
      step("jmxor:jmxrd_wait", K_JMXRD, 1'b0);
      step("jmxor:jmxrd", K_JMXRD);
      set_ir(6'b000000, 6'd20);
      set_flags(0, 0, 1);
      step("brv1:fetch", K_FETCH);
      step("brv1:decode", K_DECODE);
      step("brv1:brv", K_BRV, 1'b1, 1'b1);
      set_flags(1, 1, 0);
      step("brv0:fetch", K_FETCH);
      step("brv0:decode", K_DECODE);
      step("brv0:brv", K_BRV, 1'b1, 1'b0);

      // beq, nandi, sw
      set_ir(6'b000100, 6'b000000);
      step("beq:fetch", K_FETCH);
      step("beq:decode", K_DECODE);
      step("beq:beq", K_BEQ);
      set_ir(6'b010000, 6'b100010);
      step("nandi:fetch", K_FETCH);
      step("nandi:decode", K_DECODE);
      step("nandi:iexec", K_IEXEC);
      step("nandi:iwb", K_IWB);
      set_ir(6'b101011, 6'b000000);
      step("sw:fetch", K_FETCH);
      step("sw:decode", K_DECODE);
      step("sw:memadr", K_MEMADR);
      step("sw:memwr", K_MEMWR);

      // sw whose write never completes: 15 wait cycles, then the abort cycle
      step("swto:fetch", K_FETCH);
      step("swto:decode", K_DECODE);
      step("swto:memadr", K_MEMADR);
      for (int i = 0; i < 15; i++) step("swto:memwr_wait", K_MEMWR, 1'b0);
      step("swto:abort", K_MEMWR, 1'b0, 1'b0, 1'b1);

      // fetch timeout then refetch
      for (int i = 0; i < 15; i++) step("fto:fetch_wait", K_FETCH, 1'b0);
      step("fto:abort", K_FETCH, 1'b0, 1'b0, 1'b1);
      set_ir(6'b111111, 6'b000000);
      step("ill:fetch", K_FETCH);
      step("ill:decode", K_ILLEGAL);
      set_ir(6'b000000, 6'b100000);
      step("post_ill:fetch", K_FETCH);
      step("post_ill:decode", K_DECODE);
      step("post_ill:rexec", K_REXEC);
      step("post_ill:rwb", K_RWB);

      // asynchronous reset while sitting in MEMRD
      set_ir(6'b100011, 6'b000000);
      step("lwrst:fetch", K_FETCH);
      step("lwrst:decode", K_DECODE);
      step("lwrst:memadr", K_MEMADR);
      mem_ready = 1'b0;
      #1;
      check("lwrst:memrd_before", outs, exp_of(K_MEMRD, 1'b0, 1'b0, 1'b0));
      rst_n = 1'b0;
      #1;
      check("async_reset_outs", outs, '0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst2_idle_outs", outs, '0);
      @(posedge clk);
      #1;
      step("rst2:fetch", K_FETCH);
      step("rst2:decode", K_DECODE);

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
